imem_fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the 64-word instruction memory: owns the program counter, drives the IMEM byte address, captures the combinationally returned instruction into a 2-entry fetch queue, and hands `{pc, instruction}` pairs to decode over a valid/ready handshake. It sits between IMEM and the decode stage. It handles backpressure, branch/jump redirects with queue flush, and halt-on-sentinel.

---
 rtl/imem_fetch_ctrl.sv | 96 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches from a combinational IMEM into a
// 2-entry queue and hands {pc, instruction} pairs to decode; handles redirects and halt.
module imem_fetch_ctrl #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FETCH_en,
  output logic [7:0]  IMEM_PC,
  input  logic [31:0] IMEM_instruction,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [7:0]  out_pc,
  output logic        halted
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d, tail_q, tail_d;
  logic [1:0][39:0] ent_q, ent_d;

  logic pop, push, is_halt;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign IMEM_PC         = pc_q;
  assign out_valid       = (count_q != 2'd0);
  assign out_pc          = out_valid ? ent_q[head_q][39:32] : 8'h00;
  assign out_instruction = out_valid ? ent_q[head_q][31:0]  : 32'h0;
  assign halted          = (state_q == S_HALT);

  assign pop     = out_valid && out_ready;
  assign is_halt = (IMEM_instruction == HALT_WORD);
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign push    = (state_q == S_RUN) && FETCH_en && !redirect_valid &&
                   ((count_q != 2'd2) || pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ent_d   = ent_q;
    if (redirect_valid) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      pc_d    = {redirect_pc[7:2], 2'b00};
      state_d = ((state_q == S_HALT) || FETCH_en) ? S_RUN : S_IDLE;
    end else begin
      if (push) begin
        ent_d[tail_q] = {pc_q, IMEM_instruction};
        tail_d        = ~tail_q;
        // PC parks on the sentinel address so a later redirect is the only way out.
        if (!is_halt) pc_d = pc_q + 8'd4;
      end
      if (pop) head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      case (state_q)
        S_IDLE:  if (FETCH_en) state_d = S_RUN;
        S_RUN:   if (push && is_halt) state_d = S_HALT;
                 else if (!FETCH_en) state_d = S_IDLE;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ent_q   <= ent_d;
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_imem_fetch_ctrl;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        FETCH_en = 1'b0;
  logic [7:0]  IMEM_PC;
  logic [31:0] IMEM_instruction;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [7:0]  out_pc;
  logic        halted;

  logic [31:0] imem [64];
  int n_tests = 0;
  int n_fail  = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .FETCH_en(FETCH_en), .IMEM_PC(IMEM_PC),
    .IMEM_instruction(IMEM_instruction), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;
  assign IMEM_instruction = imem[IMEM_PC[7:2]];

  // Reference model: a plain FIFO of {pc, instr}, a PC, a "fetching" flag and a "halted" flag.
  logic [39:0] mq[$];
  logic [7:0]  m_pc = 8'h00;
  bit          m_run = 0, m_halt = 0, m_pop, m_push;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); m_pc = 8'h00; m_run = 0; m_halt = 0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc   = {redirect_pc[7:2], 2'b00};
      m_run  = m_halt ? 1'b1 : FETCH_en;
      m_halt = 0;
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = m_run && !m_halt && FETCH_en && (mq.size() < 2 || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        m_word = imem[m_pc >> 2];
        mq.push_back({m_pc, m_word});
        if (m_word == HALT) begin m_halt = 1; m_run = 0; end
        else m_pc = m_pc + 8'd4;
      end else if (!m_halt) m_run = FETCH_en;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 64; i++) imem[i] = i;
  endtask

  task automatic apply_reset();
    rst = 1; redirect_valid = 0; FETCH_en = 0; out_ready = 0;
    step(2);
    rst = 0;
  endtask

  task automatic test_reset();
    fill_linear();
    apply_reset();
    n_tests++;
    if ({IMEM_PC, out_valid, out_pc, out_instruction, halted} !== {8'h00, 1'b0, 8'h00, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got pc=%h v=%b opc=%h oi=%h h=%b, expected all zero",
               IMEM_PC, out_valid, out_pc, out_instruction, halted);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    FETCH_en = 1; out_ready = 1;
    step(1);
    n_tests++;
    if ({out_valid, IMEM_PC} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL stream_start: got v=%b pc=%h expected v=0 pc=00", out_valid, IMEM_PC);
    end
    for (int k = 0; k < 6; k++) begin
      step(1);
      n_tests++;
      if ({out_valid, out_pc, out_instruction} !== {1'b1, 8'(4*k), 32'(k)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                 k, out_valid, out_pc, out_instruction, 8'(4*k), 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    FETCH_en = 1; out_ready = 0;
    step(6);
    n_tests++;
    if ({out_valid, out_pc, IMEM_PC} !== {1'b1, 8'h00, 8'h08}) begin
      n_fail++; $display("FAIL bp_stall: got v=%b opc=%h pc=%h expected 1/00/08", out_valid, out_pc, IMEM_PC);
    end
    out_ready = 1;
    for (int k = 1; k < 4; k++) begin
      step(1);
      n_tests++;
      if ({out_valid, out_pc} !== {1'b1, 8'(4*k)}) begin
        n_fail++; $display("FAIL bp_release[%0d]: got v=%b opc=%h expected 1/%h", k, out_valid, out_pc, 8'(4*k));
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    FETCH_en = 1; out_ready = 0;
    step(4);
    redirect_valid = 1; redirect_pc = 8'h23;
    step(1);
    redirect_valid = 0;
    n_tests++;
    if ({out_valid, IMEM_PC} !== {1'b0, 8'h20}) begin
      n_fail++; $display("FAIL redirect_flush: got v=%b pc=%h expected 0/20", out_valid, IMEM_PC);
    end
    out_ready = 1;
    step(1);
    n_tests++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, 8'h20, 32'd8}) begin
      n_fail++; $display("FAIL redirect_target: got v=%b opc=%h i=%h expected 1/20/8", out_valid, out_pc, out_instruction);
    end
  endtask

  task automatic test_halt();
    fill_linear();
    imem[3] = HALT;
    apply_reset();
    FETCH_en = 1; out_ready = 1;
    step(4);
    step(1);
    n_tests++;
    if ({out_valid, out_pc, out_instruction, halted, IMEM_PC} !== {1'b1, 8'h0C, HALT, 1'b1, 8'h0C}) begin
      n_fail++; $display("FAIL halt_sentinel: got v=%b opc=%h i=%h h=%b pc=%h expected 1/0c/ffffffff/1/0c",
                         out_valid, out_pc, out_instruction, halted, IMEM_PC);
    end
    step(3);
    n_tests++;
    if ({out_valid, halted, IMEM_PC} !== {1'b0, 1'b1, 8'h0C}) begin
      n_fail++; $display("FAIL halt_hold: got v=%b h=%b pc=%h expected 0/1/0c", out_valid, halted, IMEM_PC);
    end
    redirect_valid = 1; redirect_pc = 8'h00;
    step(1);
    redirect_valid = 0;
    n_tests++;
    if ({halted, IMEM_PC} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL halt_exit: got h=%b pc=%h expected 0/00", halted, IMEM_PC);
    end
    step(1);
    n_tests++;
    if ({out_valid, out_pc} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL halt_resume: got v=%b opc=%h expected 1/00", out_valid, out_pc);
    end
    fill_linear();
  endtask

  task automatic test_wrap_pause();
    fill_linear();
    apply_reset();
    FETCH_en = 1; out_ready = 1;
    step(3);
    redirect_valid = 1; redirect_pc = 8'hFC;
    step(1);
    redirect_valid = 0;
    n_tests++;
    if (IMEM_PC !== 8'hFC) begin
      n_fail++; $display("FAIL wrap_pc: got %h expected fc", IMEM_PC);
    end
    step(1);
    n_tests++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, 8'hFC, 32'd63}) begin
      n_fail++; $display("FAIL wrap_fc: got v=%b opc=%h i=%h expected 1/fc/3f", out_valid, out_pc, out_instruction);
    end
    step(1);
    n_tests++;
    if ({out_valid, out_pc, IMEM_PC} !== {1'b1, 8'h00, 8'h04}) begin
      n_fail++; $display("FAIL wrap_00: got v=%b opc=%h pc=%h expected 1/00/04", out_valid, out_pc, IMEM_PC);
    end
    FETCH_en = 0;
    step(3);
    n_tests++;
    if ({out_valid, IMEM_PC} !== {1'b0, 8'h04}) begin
      n_fail++; $display("FAIL pause_hold: got v=%b pc=%h expected 0/04", out_valid, IMEM_PC);
    end
    FETCH_en = 1;
    step(2);
    n_tests++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, 8'h04, 32'd1}) begin
      n_fail++; $display("FAIL pause_resume: got v=%b opc=%h i=%h expected 1/04/1", out_valid, out_pc, out_instruction);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    FETCH_en = 1; out_ready = 0;
    step(4);
    rst = 1; redirect_valid = 1; redirect_pc = 8'h40;
    step(1);
    rst = 0; redirect_valid = 0;
    n_tests++;
    if ({IMEM_PC, out_valid, halted} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid: got pc=%h v=%b h=%b expected 00/0/0", IMEM_PC, out_valid, halted);
    end
    step(1);
    n_tests++;
    if ({IMEM_PC, out_valid} !== {8'h00, 1'b0}) begin
      n_fail++; $display("FAIL rst_idle: got pc=%h v=%b expected 00/0", IMEM_PC, out_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0]  e_pc;
    logic [31:0] e_i;
    for (int i = 0; i < 64; i++)
      imem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      e_pc = (mq.size() != 0) ? mq[0][39:32] : 8'h00;
      e_i  = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
      n_tests++;
      if ({out_valid, out_pc, out_instruction, IMEM_PC, halted} !==
          {mq.size() != 0, e_pc, e_i, m_pc, m_halt}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b opc=%h i=%h pc=%h h=%b expected v=%b opc=%h i=%h pc=%h h=%b",
                 c, out_valid, out_pc, out_instruction, IMEM_PC, halted,
                 mq.size() != 0, e_pc, e_i, m_pc, m_halt);
      end
      rst            = ($urandom_range(0, 99) < 2);
      FETCH_en       = ($urandom_range(0, 99) < 80);
      out_ready      = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = 8'($urandom);
      if ($urandom_range(0, 49) == 0) imem[$urandom_range(0, 63)] = $urandom;
      step(1);
    end
    rst = 0; redirect_valid = 0;
  endtask

  initial begin
    fill_linear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap_pause();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
